// File: rtl/usr_seq_shifter.sv
// Parametrised universal shift register with per-clock LOAD/SHIFT/HOLD and a
// counted-shift sequencer that issues one single-position shift per clock under BUSY/DONE.
module usr_seq_shifter #(
  parameter int WIDTH = 36,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       SEL,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN_HI,
  input  logic             SIN_LO,
  input  logic             START,
  input  logic [CNT_W-1:0] COUNT,
  output logic [WIDTH-1:0] Q,
  output logic             SOUT,
  output logic             BUSY,
  output logic             DONE
);

  localparam logic [1:0] SEL_LOAD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] MODE_ROT  = 2'b01;
  localparam logic [1:0] MODE_ARI  = 2'b10;

  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;
  logic [1:0]       mode_q, mode_d;

  // Q[WIDTH-1] holds architectural bit 0 (MSB); a right shift moves data toward Q[0].
  // Result is {shifted-out bit, new register value}. Mode 11 falls through to logical.
  function automatic logic [WIDTH:0] shift_one(
    input logic [WIDTH-1:0] q,
    input logic             left,
    input logic [1:0]       mode,
    input logic             sin_hi,
    input logic             sin_lo
  );
    logic fill;
    if (left) begin
      fill = (mode == MODE_ROT) ? q[WIDTH-1] : (mode == MODE_ARI) ? 1'b0 : sin_lo;
      return {q[WIDTH-1], q[WIDTH-2:0], fill};
    end else begin
      fill = (mode == MODE_ROT) ? q[0] : (mode == MODE_ARI) ? q[WIDTH-1] : sin_hi;
      return {q[0], fill, q[WIDTH-1:1]};
    end
  endfunction

  always_comb begin
    q_d    = q_q;
    sout_d = sout_q;
    busy_d = busy_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    left_d = left_q;
    mode_d = mode_q;
    if (busy_q) begin
      // Serial inputs stay live so logical-mode streams keep flowing during a sequence.
      {sout_d, q_d} = shift_one(q_q, left_q, mode_q, SIN_HI, SIN_LO);
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end else if (START && (SEL == SEL_RIGHT || SEL == SEL_LEFT)) begin
      left_d = (SEL == SEL_LEFT);
      mode_d = MODE;
      if (COUNT != '0) begin
        {sout_d, q_d} = shift_one(q_q, SEL == SEL_LEFT, MODE, SIN_HI, SIN_LO);
        cnt_d = COUNT - 1'b1;
      end else begin
        cnt_d = '0;
      end
      if (COUNT > CNT_W'(1)) begin
        busy_d = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end else begin
      case (SEL)
        SEL_LOAD:  q_d = D;
        SEL_RIGHT: {sout_d, q_d} = shift_one(q_q, 1'b0, MODE, SIN_HI, SIN_LO);
        SEL_LEFT:  {sout_d, q_d} = shift_one(q_q, 1'b1, MODE, SIN_HI, SIN_LO);
        default:   q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_q    <= '0;
      sout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      left_q <= 1'b0;
      mode_q <= 2'b00;
    end else begin
      q_q    <= q_d;
      sout_q <= sout_d;
      busy_q <= busy_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      left_q <= left_d;
      mode_q <= mode_d;
    end
  end

  assign Q    = q_q;
  assign SOUT = sout_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_usr_seq_shifter.sv
// Bench for usr_seq_shifter: directed sequences push expected end-of-sequence results
// into a scoreboard that a DONE-triggered monitor pops and checks.
module tb_usr_seq_shifter;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [1:0]  SEL = 2'b11;
  logic [1:0]  MODE = 2'b00;
  logic [35:0] D = '0;
  logic        SIN_HI = 1'b0;
  logic        SIN_LO = 1'b0;
  logic        START = 1'b0;
  logic [5:0]  COUNT = '0;
  logic [35:0] Q;
  logic        SOUT, BUSY, DONE;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [35:0] q;
    logic        sout;
    int          busy;
    string       name;
  } exp_t;
  exp_t sb[$];
  int busy_run = 0;

  usr_seq_shifter #(.WIDTH(36), .CNT_W(6)) dut (
    .CLK(CLK), .RESET(RESET), .SEL(SEL), .MODE(MODE), .D(D),
    .SIN_HI(SIN_HI), .SIN_LO(SIN_LO), .START(START), .COUNT(COUNT),
    .Q(Q), .SOUT(SOUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end else begin
      $display("ok   %s: %0o", name, act);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_seq(input string name, input logic [35:0] q, input logic sout, input int busy);
    exp_t e;
    e.q = q; e.sout = sout; e.busy = busy; e.name = name;
    sb.push_back(e);
  endtask

  // Returns once DONE is visible; an expired bound is reported as a failed check.
  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (DONE !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    if (DONE !== 1'b1) chk({name, "_timeout"}, 64'(n), 64'(bound + 1));
  endtask

  // Monitor: each DONE pulse retires one scoreboard entry.
  always @(negedge CLK) begin
    if (RESET === 1'b1) begin
      busy_run = 0;
    end else if (DONE === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'(DONE), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_q"}, 64'(Q), 64'(e.q));
        chk({e.name, "_sout"}, 64'(SOUT), 64'(e.sout));
        chk({e.name, "_busy_cycles"}, 64'(busy_run), 64'(e.busy));
      end
      busy_run = 0;
    end else if (BUSY === 1'b1) begin
      busy_run++;
    end
  end

  initial begin
    int dones;
    tick(); tick();
    RESET = 1'b0;
    chk("reset_q", 64'(Q), 64'(0));
    chk("reset_busy_done_sout", {61'd0, BUSY, DONE, SOUT}, 64'(0));

    // 1: load then hold
    SEL = 2'b00; D = 36'o123456701234; tick();
    chk("load_q", 64'(Q), 64'(36'o123456701234));
    SEL = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_q", 64'(Q), 64'(36'o123456701234));
      chk("hold_busy_done_sout", {61'd0, BUSY, DONE, SOUT}, 64'(0));
    end

    // 2: rotate right by 3
    MODE = 2'b01; SEL = 2'b01; START = 1'b1; COUNT = 6'd3;
    expect_seq("rot_r3", 36'o412345670123, 1'b1, 2);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("rot_r3", 20);

    // 3: arithmetic right by 6
    tick();
    SEL = 2'b00; D = 36'o400000000000; tick();
    MODE = 2'b10; SEL = 2'b01; START = 1'b1; COUNT = 6'd6;
    expect_seq("ari_r6", 36'o774000000000, 1'b0, 5);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("ari_r6", 20);

    // 4: logical left by 3; inputs scrambled while busy
    tick();
    SEL = 2'b00; D = 36'o000000000017; MODE = 2'b00; tick();
    SEL = 2'b10; SIN_LO = 1'b1; START = 1'b1; COUNT = 6'd3;
    expect_seq("log_l3", 36'o000000000177, 1'b0, 2);
    tick();
    SEL = 2'b00; D = '1; START = 1'b1; COUNT = 6'd5; MODE = 2'b01;
    wait_done("log_l3", 20);
    START = 1'b0; SEL = 2'b11; MODE = 2'b00; SIN_LO = 1'b0;
    tick();

    // 5: zero count, START with LOAD, count of one
    SEL = 2'b01; START = 1'b1; COUNT = 6'd0;
    expect_seq("cnt0", 36'o000000000177, 1'b0, 0);
    tick(); START = 1'b0; SEL = 2'b11;
    chk("cnt0_done_now", 64'(DONE), 64'(1));
    tick();
    chk("cnt0_done_clear", {62'd0, BUSY, DONE}, 64'(0));
    SEL = 2'b00; D = 36'o55; START = 1'b1; tick();
    START = 1'b0; SEL = 2'b11;
    chk("start_load_q", 64'(Q), 64'(36'o55));
    chk("start_load_done", 64'(DONE), 64'(0));
    MODE = 2'b01; SEL = 2'b10; START = 1'b1; COUNT = 6'd1;
    expect_seq("rot_l1", 36'o132, 1'b0, 0);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("rot_l1", 5);
    tick();

    // Back-to-back: second START lands in the DONE cycle of the first
    SEL = 2'b01; START = 1'b1; COUNT = 6'd2;
    expect_seq("rot_r2", 36'o400000000026, 1'b1, 1);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("rot_r2", 10);
    MODE = 2'b00; SEL = 2'b10; SIN_LO = 1'b0; START = 1'b1; COUNT = 6'd1;
    expect_seq("b2b_l1", 36'o54, 1'b1, 0);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("b2b_l1", 5);
    tick();

    // 6: reset aborts a long sequence
    SEL = 2'b00; D = 36'o123456701234; tick();
    SEL = 2'b01; MODE = 2'b00; SIN_HI = 1'b0; START = 1'b1; COUNT = 6'd20;
    tick(); START = 1'b0; SEL = 2'b11;
    for (int i = 0; i < 4; i++) tick();
    chk("abort_busy_before", 64'(BUSY), 64'(1));
    RESET = 1'b1; tick(); RESET = 1'b0;
    chk("abort_q", 64'(Q), 64'(0));
    chk("abort_busy_done_sout", {61'd0, BUSY, DONE, SOUT}, 64'(0));
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (DONE === 1'b1) dones++;
    end
    chk("abort_no_late_done", 64'(dones), 64'(0));

    SEL = 2'b00; D = 36'o10; tick();
    SEL = 2'b01; SIN_HI = 1'b1; START = 1'b1; COUNT = 6'd4;
    expect_seq("post_reset_r4", 36'o740000000000, 1'b1, 3);
    tick(); START = 1'b0; SEL = 2'b11;
    wait_done("post_reset_r4", 20);
    tick(); tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
